// File: rtl/spi_flash_reader.sv
// rtl/spi_flash_reader.sv - single-lane SPI flash read initiator (command 0x03, SCK mode 0)
module spi_flash_reader #(
    parameter int unsigned SCK_HALF = 2,   // system clocks per SCK half-period, 1..255
    parameter int unsigned CS_HIGH  = 4    // minimum system clocks csb stays high between transfers, 1..255
) (
    input  logic        wb_clk_i,          // system clock
    input  logic        wb_rst_i,          // synchronous reset, active-high
    input  logic        i_req_valid,       // read request valid
    output logic        o_req_ready,       // block can accept a request
    input  logic [23:0] i_req_addr,        // flash byte address, any alignment
    output logic        o_rsp_valid,       // one-cycle pulse, o_rsp_data valid
    output logic [31:0] o_rsp_data,        // bytes addr..addr+3 in [7:0]..[31:24]
    output logic        o_busy,            // high from accept until the csb gap ends
    output logic        o_flash_csb,       // chip select, active-low
    output logic        o_flash_clk,       // SCK, idles low
    output logic        o_flash_io0,       // MOSI
    input  logic        i_flash_io1        // MISO
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam logic [7:0] DIV_LAST  = 8'(SCK_HALF - 1);
    localparam logic [7:0] GAP_LAST  = 8'(CS_HIGH - 1);
    localparam logic [6:0] BIT_TOTAL = 7'd64;
    localparam logic [6:0] BIT_DATA  = 7'd32;

    state_t      state;
    state_t      state_next;

    logic [7:0]  div_cnt;
    logic [6:0]  bit_cnt;      // SCK rising edges issued so far in this transfer
    logic [7:0]  gap_cnt;
    logic [63:0] tx_shift;     // {cmd, addr, zeros}; bit 63 is always on MOSI
    logic [31:0] rx_shift;
    logic        sck_q;
    logic        csb_q;
    logic        rsp_valid_q;
    logic [31:0] rsp_data_q;

    logic        accept;
    logic        half_tick;
    logic        sck_rise;
    logic        sck_fall;
    logic        last_fall;
    logic        gap_done;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        accept     = 1'b0;
        half_tick  = 1'b0;
        sck_rise   = 1'b0;
        sck_fall   = 1'b0;
        last_fall  = 1'b0;
        gap_done   = 1'b0;
        state_next = state;
        case (state)
            ST_IDLE: begin
                accept = i_req_valid;
                if (accept) begin
                    state_next = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                half_tick = (div_cnt == DIV_LAST);
                sck_rise  = half_tick && !sck_q;
                sck_fall  = half_tick && sck_q;
                // The transfer ends on the falling edge that follows the 64th rise.
                last_fall = sck_fall && (bit_cnt == BIT_TOTAL);
                if (last_fall) begin
                    state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                gap_done = (gap_cnt == GAP_LAST);
                if (gap_done) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            div_cnt     <= 8'd0;
            bit_cnt     <= 7'd0;
            gap_cnt     <= 8'd0;
            tx_shift    <= 64'd0;
            rx_shift    <= 32'd0;
            sck_q       <= 1'b0;
            csb_q       <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= 32'd0;
        end else begin
            rsp_valid_q <= 1'b0;

            if (accept) begin
                tx_shift <= {8'h03, i_req_addr, 32'd0};
                div_cnt  <= 8'd0;
                bit_cnt  <= 7'd0;
                sck_q    <= 1'b0;
                csb_q    <= 1'b0;
            end

            if (state == ST_SHIFT) begin
                div_cnt <= half_tick ? 8'd0 : div_cnt + 8'd1;
                if (half_tick) begin
                    sck_q <= ~sck_q;
                end
                // MISO is captured with the edge that raises SCK, i.e. the value
                // the flash has held for the whole low half-period.
                if (sck_rise) begin
                    bit_cnt <= bit_cnt + 7'd1;
                    if (bit_cnt >= BIT_DATA) begin
                        rx_shift <= {rx_shift[30:0], i_flash_io1};
                    end
                end
                if (sck_fall) begin
                    tx_shift <= {tx_shift[62:0], 1'b0};
                end
                if (last_fall) begin
                    csb_q       <= 1'b1;
                    rsp_valid_q <= 1'b1;
                    // First byte on the wire lands in the low byte.
                    rsp_data_q  <= {rx_shift[7:0], rx_shift[15:8], rx_shift[23:16], rx_shift[31:24]};
                    gap_cnt     <= 8'd0;
                end
            end

            if ((state == ST_GAP) && !gap_done) begin
                gap_cnt <= gap_cnt + 8'd1;
            end
        end
    end

    assign o_req_ready = (state == ST_IDLE);
    assign o_busy      = (state != ST_IDLE);
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_data  = rsp_data_q;
    assign o_flash_csb = csb_q;
    assign o_flash_clk = sck_q;
    assign o_flash_io0 = tx_shift[63];

endmodule

// File: tb/tb_spi_flash_reader.sv
// tb/tb_spi_flash_reader.sv - self-checking bench for spi_flash_reader
module tb_spi_flash_reader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst      = 1'b1;
    logic [23:0] req_addr = 24'd0;
    logic        valid_s  = 1'b0;
    logic        valid_f  = 1'b0;
    logic        miso     = 1'b0;
    logic        sel      = 1'b0;

    logic        ready_s, rsp_valid_s, busy_s, csb_s, sck_s, mosi_s;
    logic [31:0] data_s;
    logic        ready_f, rsp_valid_f, busy_f, csb_f, sck_f, mosi_f;
    logic [31:0] data_f;

    spi_flash_reader #(.SCK_HALF(2), .CS_HIGH(4)) u_dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .i_req_valid (valid_s),
        .o_req_ready (ready_s),
        .i_req_addr  (req_addr),
        .o_rsp_valid (rsp_valid_s),
        .o_rsp_data  (data_s),
        .o_busy      (busy_s),
        .o_flash_csb (csb_s),
        .o_flash_clk (sck_s),
        .o_flash_io0 (mosi_s),
        .i_flash_io1 (miso)
    );

    spi_flash_reader #(.SCK_HALF(1), .CS_HIGH(1)) u_dut_fast (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .i_req_valid (valid_f),
        .o_req_ready (ready_f),
        .i_req_addr  (req_addr),
        .o_rsp_valid (rsp_valid_f),
        .o_rsp_data  (data_f),
        .o_busy      (busy_f),
        .o_flash_csb (csb_f),
        .o_flash_clk (sck_f),
        .o_flash_io0 (mosi_f),
        .i_flash_io1 (miso)
    );

    logic        m_ready, m_rsp_valid, m_busy, m_csb, m_sck, m_mosi;
    logic [31:0] m_data;
    assign m_ready     = sel ? ready_f     : ready_s;
    assign m_rsp_valid = sel ? rsp_valid_f : rsp_valid_s;
    assign m_busy      = sel ? busy_f      : busy_s;
    assign m_csb       = sel ? csb_f       : csb_s;
    assign m_sck       = sel ? sck_f       : sck_s;
    assign m_mosi      = sel ? mosi_f      : mosi_s;
    assign m_data      = sel ? data_f      : data_s;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Flash contents: explicit bytes where written, otherwise a fixed hash of the address.
    logic [7:0] mem [logic [23:0]];

    function automatic logic [7:0] byte_at(input logic [23:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
    endfunction

    function automatic logic [31:0] exp_word(input logic [23:0] a);
        return {byte_at(a + 24'd3), byte_at(a + 24'd2), byte_at(a + 24'd1), byte_at(a)};
    endfunction

    // Mode-0 read responder: shifts in command+address on rising edges,
    // drives data on falling edges, and drives junk before the data phase.
    int          rise_cnt = 0;
    logic [31:0] hdr      = 32'd0;
    int          data_mosi_ones = 0;
    int          md;
    logic [7:0]  mb;

    always @(negedge m_csb) begin
        rise_cnt = 0;
        hdr      = 32'd0;
        miso     = 1'($urandom);
    end

    always @(posedge m_sck) begin
        if (!m_csb) begin
            if (rise_cnt < 32) hdr = {hdr[30:0], m_mosi};
            else if (m_mosi !== 1'b0) data_mosi_ones++;
            rise_cnt++;
        end
    end

    always @(negedge m_sck) begin
        if (!m_csb) begin
            if (rise_cnt >= 32 && rise_cnt < 64) begin
                md   = rise_cnt - 32;
                mb   = byte_at(hdr[23:0] + 24'(md / 8));
                miso = mb[7 - (md % 8)];
            end else begin
                miso = 1'($urandom);
            end
        end
    end

    // Pin monitor sampled mid-cycle.
    logic p_csb = 1'b1, p_sck = 1'b0, p_mosi = 1'b0, p_rsp = 1'b0;
    int mosi_viol = 0, edge_viol = 0, sck_rises = 0, glitch = 0, run = 0;
    int hi_run = 0, last_gap = 0, rsp_cnt = 0, pulse_viol = 0;

    always @(negedge clk) begin
        if (!m_csb && m_sck && (m_mosi !== p_mosi)) mosi_viol++;
        if ((m_csb !== p_csb) && (m_sck !== 1'b0)) edge_viol++;
        if (m_csb && m_sck) edge_viol++;
        if (!m_csb && m_sck && !p_sck) sck_rises++;
        if (!m_csb) begin
            if (p_csb) run = 1;
            else if (m_sck !== p_sck) begin
                if (run != (sel ? 1 : 2)) glitch++;
                run = 1;
            end else run++;
        end
        if (m_csb) hi_run++;
        else begin
            if (p_csb) last_gap = hi_run;
            hi_run = 0;
        end
        if (m_rsp_valid) begin
            rsp_cnt++;
            if (p_rsp) pulse_viol++;
        end
        p_csb  = m_csb;
        p_sck  = m_sck;
        p_mosi = m_mosi;
        p_rsp  = m_rsp_valid;
    end

    // Issue one request from a negedge; lat is the cycle (handshake = cycle 0)
    // in which the response is seen, or -1 on timeout.
    task automatic do_req(input logic [23:0] a, input bit hold, output logic [31:0] data,
                          output int lat, output int rdy_viol);
        int n;
        lat      = -1;
        data     = 32'hxxxxxxxx;
        rdy_viol = 0;
        req_addr = a;
        if (sel) valid_f = 1'b1; else valid_s = 1'b1;
        n = 0;
        while (!m_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!m_ready) begin
            valid_s = 1'b0;
            valid_f = 1'b0;
            return;
        end
        @(negedge clk);
        if (!hold) begin
            valid_s = 1'b0;
            valid_f = 1'b0;
        end
        for (n = 1; n <= 1000; n++) begin
            if (m_rsp_valid) begin
                lat  = n;
                data = m_data;
                break;
            end
            if (m_ready) rdy_viol++;
            @(negedge clk);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d;
        logic [23:0] a;
        int          lat, rv, base, n;

        mem[24'h000000] = 8'h13; mem[24'h000001] = 8'h00;
        mem[24'h000002] = 8'h00; mem[24'h000003] = 8'h6F;
        mem[24'h100003] = 8'hAA; mem[24'h100004] = 8'hBB;
        mem[24'h100005] = 8'hCC; mem[24'h100006] = 8'hDD;

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_csb",   32'(csb_s),       32'd1);
        check("rst_sck",   32'(sck_s),       32'd0);
        check("rst_mosi",  32'(mosi_s),      32'd0);
        check("rst_rspv",  32'(rsp_valid_s), 32'd0);
        check("rst_data",  data_s,           32'd0);
        check("rst_busy",  32'(busy_s),      32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(ready_s),     32'd1);

        // Address 0, known bytes
        sck_rises = 0;
        do_req(24'h000000, 1'b0, d, lat, rv);
        check("t1_data",   d,           32'h6F000013);
        check("t1_model",  d,           exp_word(24'h000000));
        check("t1_lat",    32'(lat),    32'd257);
        check("t1_mosi",   hdr,         32'h03000000);
        check("t1_rises",  32'(sck_rises), 32'd64);
        check("t1_ready",  32'(rv),     32'd0);
        repeat (3) @(negedge clk);
        check("t1_hold",   m_data,      32'h6F000013);
        check("t1_pulse",  32'(m_rsp_valid), 32'd0);

        // Unaligned address
        sck_rises = 0;
        do_req(24'h100003, 1'b0, d, lat, rv);
        check("t2_data",   d,           32'hDDCCBBAA);
        check("t2_mosi",   hdr,         32'h03100003);
        check("t2_rises",  32'(sck_rises), 32'd64);
        check("t2_lat",    32'(lat),    32'd257);

        // Back-to-back with valid held high
        base = rsp_cnt;
        do_req(24'h000000, 1'b1, d, lat, rv);
        check("t3_data0",  d,           exp_word(24'h000000));
        check("t3_ready0", 32'(rv),     32'd0);
        do_req(24'h000004, 1'b0, d, lat, rv);
        check("t3_data1",  d,           exp_word(24'h000004));
        check("t3_lat1",   32'(lat),    32'd257);
        check("t3_gap",    32'(last_gap >= 4), 32'd1);
        check("t3_pulses", 32'(rsp_cnt - base), 32'd2);

        // Reset in cycle 100 of a transfer
        a = 24'($urandom);
        req_addr = a;
        valid_s  = 1'b1;
        n = 0;
        while (!ready_s && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        valid_s = 1'b0;
        repeat (99) @(negedge clk);
        base = rsp_cnt;
        rst  = 1'b1;
        @(negedge clk);
        check("t4_csb",    32'(csb_s),  32'd1);
        check("t4_sck",    32'(sck_s),  32'd0);
        check("t4_busy",   32'(busy_s), 32'd0);
        check("t4_data",   data_s,      32'd0);
        rst = 1'b0;
        repeat (300) @(negedge clk);
        check("t4_norsp",  32'(rsp_cnt - base), 32'd0);
        a = 24'($urandom);
        do_req(a, 1'b0, d, lat, rv);
        check("t4_after",  d,           exp_word(a));
        check("t4_lat",    32'(lat),    32'd257);

        // Random addresses, including the top-of-flash wrap
        for (int i = 0; i < 4; i++) begin
            a = (i == 0) ? 24'hFFFFFE : 24'($urandom);
            for (int j = 0; j < 4; j++) if ($urandom_range(1) == 1) mem[a + 24'(j)] = 8'($urandom);
            do_req(a, 1'b0, d, lat, rv);
            check($sformatf("t5_data%0d", i), d, exp_word(a));
            check($sformatf("t5_lat%0d", i),  32'(lat), 32'd257);
            check($sformatf("t5_mosi%0d", i), hdr, {8'h03, a});
        end

        // Fast configuration: SCK_HALF=1, CS_HIGH=1
        repeat (10) @(negedge clk);
        sel = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            a = 24'($urandom);
            sck_rises = 0;
            do_req(a, 1'b0, d, lat, rv);
            check($sformatf("t6_data%0d", i),  d, exp_word(a));
            check($sformatf("t6_lat%0d", i),   32'(lat), 32'd129);
            check($sformatf("t6_rises%0d", i), 32'(sck_rises), 32'd64);
        end
        repeat (5) @(negedge clk);

        check("mosi_stable",   32'(mosi_viol),      32'd0);
        check("sck_at_csb",    32'(edge_viol),      32'd0);
        check("sck_glitch",    32'(glitch),         32'd0);
        check("mosi_data_zero",32'(data_mosi_ones), 32'd0);
        check("rsp_one_cycle", 32'(pulse_viol),     32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
